// File: rtl/wifi_interleave_pkg.sv
// Shared constants, state encodings and block-size helpers for the 802.11a
// transmit interleaver (BPSK SIGNAL symbol followed by QPSK data symbols).
package wifi_interleave_pkg;

    localparam int unsigned NCBPS_SIG  = 48;
    localparam int unsigned NCBPS_DATA = 96;
    localparam int unsigned NCOL       = 16;

    localparam int unsigned BANK_W = NCBPS_DATA;
    localparam int unsigned CNT_W  = $clog2(NCBPS_DATA);
    localparam int unsigned COL_W  = $clog2(NCBPS_DATA / NCOL + 1);
    localparam int unsigned ROW_W  = $clog2(NCOL);

    typedef enum logic {
        RD_IDLE,
        RD_READ
    } rd_state_t;

    typedef enum logic [1:0] {
        WR_RUN,   // accepting coded bits
        WR_PAD,   // zero-filling the rest of the final block
        WR_DONE   // frame written, waiting for the reader to drain it
    } wr_state_t;

    // Number of interleaver columns walked per row (N/16).
    function automatic logic [COL_W-1:0] cols_for(input logic sig);
        return sig ? COL_W'(NCBPS_SIG / NCOL) : COL_W'(NCBPS_DATA / NCOL);
    endfunction

    // Index of the final bit of a block.
    function automatic logic [CNT_W-1:0] last_idx(input logic sig);
        return sig ? CNT_W'(NCBPS_SIG - 1) : CNT_W'(NCBPS_DATA - 1);
    endfunction

endpackage

// File: rtl/interleave_addr_gen_wifi.sv
// Read-address generator: for output index i walks k = 16*(i mod M) + i/M
// using a column counter (0..M-1) and a row counter (0..15).
module interleave_addr_gen_wifi
    import wifi_interleave_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic             adv_i,
    input  logic [COL_W-1:0] m_i,
    output logic [CNT_W-1:0] addr_o,
    output logic             last_o
);

    logic [COL_W-1:0] col_q;
    logic [ROW_W-1:0] row_q;
    logic             col_wrap;

    // Column fastest, row slowest; since row < 16, 16*col+row is a concatenation.
    always_comb begin
        col_wrap = (col_q == m_i - COL_W'(1));
        last_o   = col_wrap && (row_q == ROW_W'(NCOL - 1));
        addr_o   = {col_q, row_q};
    end

    // Counters restart on start and wrap to zero after the final address.
    always_ff @(posedge clk) begin
        if (reset || start_i) begin
            col_q <= '0;
            row_q <= '0;
        end else if (adv_i) begin
            if (col_wrap) begin
                col_q <= '0;
                row_q <= row_q + ROW_W'(1);
            end else begin
                col_q <= col_q + COL_W'(1);
            end
        end
    end

endmodule

// File: rtl/tx_interleaver96_wifi.sv
// Transmit block interleaver: serial coded bits fill a ping-pong pair of
// 96-bit banks in arrival order; each full bank is read out serially in
// interleaved order. First block of a frame is 48 bits, later ones 96.
module tx_interleaver96_wifi
    import wifi_interleave_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic data_in,
    input  logic valid_in,
    input  logic last_in,
    output logic data_out,
    output logic valid_out,
    output logic block_start,
    output logic finished
);

    logic [BANK_W-1:0] bank_q [2];
    logic [1:0]        full_q;      // bank holds a complete block
    logic [1:0]        sig_q;       // bank holds a 48-bit SIGNAL block
    logic [1:0]        eof_q;       // bank holds the final block of the frame

    logic              wr_bank_q;
    logic [CNT_W-1:0]  wr_cnt_q;
    wr_state_t         wr_state_q;
    logic              first_blk_q;
    logic              finished_q;

    rd_state_t         rd_state_q;
    logic              rd_bank_q;
    logic              fin_pend_q;
    logic              data_out_q;
    logic              valid_out_q;
    logic              block_start_q;

    logic [CNT_W-1:0]  gen_addr;
    logic              gen_last;
    logic              gen_start;
    logic              rd_active;
    logic              rd_free;
    logic              wr_room;
    logic              wr_accept;
    logic              wr_do;
    logic              wr_bit;
    logic              wr_blk_end;
    logic              wr_eof;

    // Handshake between writer and reader, including same-cycle bank release.
    always_comb begin
        rd_active  = enable && (rd_state_q == RD_READ);
        rd_free    = rd_active && gen_last;
        gen_start  = enable && (rd_state_q == RD_IDLE) && full_q[rd_bank_q];
        // A bank being released this cycle may take the next block's bit 0,
        // which keeps a 1 bit/cycle stream free of overrun at block seams.
        wr_room    = !full_q[wr_bank_q] || (rd_free && (rd_bank_q == wr_bank_q));
        wr_accept  = enable && valid_in && (wr_state_q == WR_RUN);
        wr_do      = (wr_accept && wr_room) || (enable && (wr_state_q == WR_PAD) && wr_room);
        wr_bit     = (wr_state_q == WR_PAD) ? 1'b0 : data_in;
        wr_blk_end = (wr_cnt_q == last_idx(first_blk_q));
        wr_eof     = (wr_state_q == WR_PAD) || last_in;
    end

    interleave_addr_gen_wifi u_addr_gen (
        .clk     (clk),
        .reset   (reset),
        .start_i (gen_start),
        .adv_i   (rd_active),
        .m_i     (cols_for(sig_q[rd_bank_q])),
        .addr_o  (gen_addr),
        .last_o  (gen_last)
    );

    // Bank storage: bit k of the block is written at position k.
    always_ff @(posedge clk) begin
        if (!reset && wr_do) begin
            bank_q[wr_bank_q][wr_cnt_q] <= wr_bit;
        end
    end

    // Writer, zero padding, bank bookkeeping and frame-level finished flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_bank_q   <= 1'b0;
            wr_cnt_q    <= '0;
            wr_state_q  <= WR_RUN;
            first_blk_q <= 1'b1;
            finished_q  <= 1'b1;
            full_q      <= '0;
            sig_q       <= '0;
            eof_q       <= '0;
        end else if (enable) begin
            if (rd_free) begin
                full_q[rd_bank_q] <= 1'b0;
            end
            if (wr_do) begin
                if (finished_q) begin
                    finished_q <= 1'b0;
                end
                if (wr_blk_end) begin
                    full_q[wr_bank_q] <= 1'b1;
                    sig_q[wr_bank_q]  <= first_blk_q;
                    eof_q[wr_bank_q]  <= wr_eof;
                    wr_bank_q         <= ~wr_bank_q;
                    wr_cnt_q          <= '0;
                    first_blk_q       <= 1'b0;
                    if (wr_eof) begin
                        wr_state_q <= WR_DONE;
                    end
                end else begin
                    wr_cnt_q <= wr_cnt_q + CNT_W'(1);
                    if ((wr_state_q == WR_RUN) && last_in) begin
                        wr_state_q <= WR_PAD;
                    end
                end
            end
            if (fin_pend_q) begin
                finished_q  <= 1'b1;
                wr_state_q  <= WR_RUN;
                first_blk_q <= 1'b1;
            end
        end
    end

    // Overrun would silently drop a coded bit; cannot happen at one bit per cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(wr_accept && !wr_room));
        end
    end

    // Reader FSM with registered outputs; drains banks in the order written.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_state_q    <= RD_IDLE;
            rd_bank_q     <= 1'b0;
            fin_pend_q    <= 1'b0;
            data_out_q    <= 1'b0;
            valid_out_q   <= 1'b0;
            block_start_q <= 1'b0;
        end else if (enable) begin
            fin_pend_q <= 1'b0;
            case (rd_state_q)
                RD_IDLE: begin
                    valid_out_q   <= 1'b0;
                    block_start_q <= 1'b0;
                    if (full_q[rd_bank_q]) begin
                        rd_state_q <= RD_READ;
                    end
                end
                RD_READ: begin
                    data_out_q    <= bank_q[rd_bank_q][gen_addr];
                    valid_out_q   <= 1'b1;
                    block_start_q <= (gen_addr == '0);
                    if (gen_last) begin
                        rd_bank_q  <= ~rd_bank_q;
                        fin_pend_q <= eof_q[rd_bank_q];
                        if (!full_q[~rd_bank_q]) begin
                            rd_state_q <= RD_IDLE;
                        end
                    end
                end
                default: rd_state_q <= RD_IDLE;
            endcase
        end
    end

    always_comb begin
        data_out    = data_out_q;
        valid_out   = valid_out_q;
        block_start = block_start_q;
        finished    = finished_q;
    end

endmodule

// File: tb/tb_tx_interleaver96_wifi.sv
// Self-checking bench for tx_interleaver96_wifi: table of single-hot frames
// plus hand-written sequences for continuous input, padding, stall and reset.
module tb_tx_interleaver96_wifi;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic enable = 1'b1;
    logic data_in = 1'b0;
    logic valid_in = 1'b0;
    logic last_in = 1'b0;
    logic data_out, valid_out, block_start, finished;

    tx_interleaver96_wifi dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .data_in     (data_in),
        .valid_in    (valid_in),
        .last_in     (last_in),
        .data_out    (data_out),
        .valid_out   (valid_out),
        .block_start (block_start),
        .finished    (finished)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit is_data;   // 0: SIGNAL-only frame, 1: SIGNAL + one data block
        int hot_k;     // write position of the single 1
        int exp_i;     // output position where it must appear
    } vec_t;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    logic en_at_edge = 1'b1;
    logic fin_prev = 1'b1;
    int   fin_rise = -1;

    logic fbits[$];
    int   wt[$];
    logic obits[$];
    logic obs[$];
    int   ot[$];
    logic exp_bits[$];
    logic exp_bs[$];

    always @(posedge clk) begin
        cyc        <= cyc + 1;
        en_at_edge <= enable;
    end

    always @(negedge clk) begin
        if (valid_out === 1'b1 && en_at_edge === 1'b1) begin
            obits.push_back(data_out);
            obs.push_back(block_start);
            ot.push_back(cyc);
        end
        if (finished === 1'b1 && fin_prev !== 1'b1) fin_rise = cyc;
        fin_prev = finished;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, $signed(act), $signed(req));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int junk);
        wt.delete();
        for (int j = 0; j < fbits.size(); j++) begin
            data_in  = fbits[j];
            valid_in = 1'b1;
            last_in  = (j == fbits.size() - 1);
            tick();
            wt.push_back(cyc);
        end
        last_in = 1'b0;
        for (int j = 0; j < junk; j++) begin
            data_in  = 1'b1;
            valid_in = 1'b1;
            tick();
        end
        valid_in = 1'b0;
        data_in  = 1'b0;
    endtask

    task automatic wait_fin(input string nm, input int budget);
        int n = 0;
        while (finished !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        chk({nm, " finished"}, 32'(finished), 1);
        tick();
    endtask

    // Reference: 48-bit first block, 96-bit later blocks, zero fill past the end.
    function automatic void build_exp();
        int pos = 0;
        int blk = 0;
        int nb = fbits.size();
        exp_bits.delete();
        exp_bs.delete();
        while (pos < nb) begin
            int n = (blk == 0) ? 48 : 96;
            int m = n / 16;
            for (int i = 0; i < n; i++) begin
                int k = 16 * (i % m) + i / m;
                exp_bits.push_back((pos + k < nb) ? fbits[pos + k] : 1'b0);
                exp_bs.push_back(i == 0);
            end
            pos += n;
            blk++;
        end
    endfunction

    task automatic check_frame(input string nm, input int ob0);
        int n = obits.size() - ob0;
        int mism = 0;
        int bsm = 0;
        build_exp();
        chk({nm, " count"}, n, exp_bits.size());
        for (int j = 0; j < n && j < exp_bits.size(); j++) begin
            if (obits[ob0 + j] !== exp_bits[j]) mism++;
            if (obs[ob0 + j] !== exp_bs[j]) bsm++;
        end
        chk({nm, " data errors"}, mism, 0);
        chk({nm, " block_start errors"}, bsm, 0);
        if (n > 0 && wt.size() >= 48) begin
            chk({nm, " first-out latency"}, ot[ob0] - wt[47], 2);
            chk({nm, " finished delay"}, fin_rise - ot[ob0 + n - 1], 1);
        end
    endtask

    task automatic hot_check(input string nm, input int ob0, input int base, input int len, input int exp_i);
        int first = -1;
        int ones = 0;
        for (int j = 0; j < len; j++) begin
            if (ob0 + base + j < obits.size() && obits[ob0 + base + j] === 1'b1) begin
                if (first < 0) first = j;
                ones++;
            end
        end
        chk({nm, " hot position"}, first, exp_i);
        chk({nm, " ones"}, ones, 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        vec_t tbl[$];
        int   ob0;
        int   gaps;
        int   n;
        logic d_hold, v_hold;
        int   frozen;

        tbl.push_back('{0, 1, 3});
        tbl.push_back('{0, 0, 0});
        tbl.push_back('{0, 16, 1});
        tbl.push_back('{0, 47, 47});
        tbl.push_back('{1, 17, 7});
        tbl.push_back('{1, 16, 1});
        tbl.push_back('{1, 50, 15});
        tbl.push_back('{1, 95, 95});
        for (int k = 0; k < 16; k++) tbl.push_back('{1, k, 6 * k});

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset data_out", 32'(data_out), 0);
        chk("reset valid_out", 32'(valid_out), 0);
        chk("reset block_start", 32'(block_start), 0);
        chk("reset finished", 32'(finished), 1);
        reset = 1'b0;
        tick();

        // Single-hot frames
        for (int t = 0; t < tbl.size(); t++) begin
            fbits.delete();
            if (tbl[t].is_data) for (int j = 0; j < 48; j++) fbits.push_back(1'b0);
            for (int j = 0; j < (tbl[t].is_data ? 96 : 48); j++)
                fbits.push_back(j == tbl[t].hot_k);
            ob0 = obits.size();
            drive(0);
            wait_fin($sformatf("vec%0d", t), 400);
            check_frame($sformatf("vec%0d", t), ob0);
            hot_check($sformatf("vec%0d", t), ob0, tbl[t].is_data ? 48 : 0,
                      tbl[t].is_data ? 96 : 48, tbl[t].exp_i);
        end

        // Continuous stream: SIGNAL + three data blocks
        fbits.delete();
        for (int j = 0; j < 48 + 3 * 96; j++) fbits.push_back(1'($urandom_range(0, 1)));
        ob0 = obits.size();
        drive(0);
        wait_fin("stream", 400);
        check_frame("stream", ob0);
        n = obits.size() - ob0;
        gaps = 0;
        for (int j = 0; j + 1 < n; j++)
            if (j != 47 && ot[ob0 + j + 1] != ot[ob0 + j] + 1) gaps++;
        chk("stream gaps", gaps, 0);

        // Early last_in at data bit 40; extra valid_in during pad is ignored
        fbits.delete();
        for (int j = 0; j < 48 + 41; j++) fbits.push_back(1'($urandom_range(0, 1)));
        ob0 = obits.size();
        drive(60);
        wait_fin("pad", 400);
        check_frame("pad", ob0);

        // Stall for 5 cycles in the middle of a data block readout
        fbits.delete();
        for (int j = 0; j < 144; j++) fbits.push_back(1'($urandom_range(0, 1)));
        ob0 = obits.size();
        drive(0);
        repeat (20) tick();
        d_hold = data_out;
        v_hold = valid_out;
        chk("stall mid-read valid", 32'(v_hold), 1);
        enable = 1'b0;
        frozen = 0;
        for (int j = 0; j < 5; j++) begin
            tick();
            if (data_out !== d_hold || valid_out !== v_hold) frozen++;
        end
        enable = 1'b1;
        chk("stall output changes", frozen, 0);
        wait_fin("stall", 400);
        check_frame("stall", ob0);

        // Reset at data output i=20 aborts the frame
        fbits.delete();
        for (int j = 0; j < 144; j++) fbits.push_back(1'($urandom_range(0, 1)));
        ob0 = obits.size();
        drive(0);
        n = 0;
        while (obits.size() - ob0 < 48 + 21 && n < 300) begin
            tick();
            n++;
        end
        chk("abort reached i=20", 32'(obits.size() - ob0 >= 48 + 21), 1);
        reset = 1'b1;
        tick();
        chk("abort valid_out", 32'(valid_out), 0);
        chk("abort finished", 32'(finished), 1);
        reset = 1'b0;
        ob0 = obits.size();
        repeat (10) tick();
        chk("abort quiet outputs", obits.size() - ob0, 0);
        fbits.delete();
        for (int j = 0; j < 48; j++) fbits.push_back(j == 1);
        ob0 = obits.size();
        drive(0);
        wait_fin("after abort", 400);
        check_frame("after abort", ob0);
        hot_check("after abort", ob0, 0, 48, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
